// File: rtl/sprite_pkg.sv
// Shared constants and types for the drum sprite path: grid geometry, scan-counter widths
// and the sprite index type shared with the downstream priority selector.
package sprite_pkg;

  localparam int unsigned NUM_SPRITES = 14;
  localparam int unsigned GRID_COLS   = 7;
  localparam int unsigned HCOUNT_W    = 11;
  localparam int unsigned VCOUNT_W    = 10;

  // Visible area that every sprite box must fit inside.
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Selector output: 0 = no sprite, otherwise sprite (idx - 1).
  typedef logic [3:0] sprite_idx_t;
  localparam sprite_idx_t SPRITE_NONE = 4'd0;

  function automatic int unsigned sprite_col(int unsigned idx);
    return idx % GRID_COLS;
  endfunction

  function automatic int unsigned sprite_row(int unsigned idx);
    return idx / GRID_COLS;
  endfunction

  function automatic int unsigned box_left(int unsigned idx, int unsigned origin_x,
                                           int unsigned col_pitch);
    return origin_x + sprite_col(idx) * col_pitch;
  endfunction

  function automatic int unsigned box_top(int unsigned idx, int unsigned origin_y,
                                          int unsigned row_pitch);
    return origin_y + sprite_row(idx) * row_pitch;
  endfunction

endpackage

// File: rtl/sprite_flash_timer.sv
// One drum flash timer: loads FLASH_FRAMES on a trigger, counts down once per frame,
// and reports a registered "still lit" flag.
module sprite_flash_timer #(
  parameter int unsigned FLASH_FRAMES = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic tick,
  output logic lit
);

  localparam int unsigned TW = $clog2(FLASH_FRAMES + 1);

  logic [TW-1:0] count_q, count_d;
  logic          lit_q;

  // Load has priority over the frame decrement; zero saturates.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = TW'(FLASH_FRAMES);
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - TW'(1);
    end
  end

  // lit tracks the post-edge count so it equals (count_q != 0) at all times.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      lit_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      lit_q   <= (count_d != '0);
    end
  end

  assign lit = lit_q;

  count_in_range_a: assert property (@(posedge clk) disable iff (!reset_n)
    count_q <= TW'(FLASH_FRAMES));

  lit_matches_count_a: assert property (@(posedge clk) disable iff (!reset_n)
    lit_q == (count_q != '0));

endmodule

// File: rtl/sprite_flash_mask.sv
// Per-pixel drum sprite hit vector: fixed-grid box compare gated by per-drum flash timers,
// registered together with the delayed scan position.
module sprite_flash_mask
  import sprite_pkg::*;
#(
  parameter int unsigned ORIGIN_X     = 64,
  parameter int unsigned ORIGIN_Y     = 160,
  parameter int unsigned COL_PITCH    = 80,
  parameter int unsigned ROW_PITCH    = 128,
  parameter int unsigned SPR_W        = 64,
  parameter int unsigned SPR_H        = 64,
  parameter int unsigned FLASH_FRAMES = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [HCOUNT_W-1:0]    hcount,
  input  logic [VCOUNT_W-1:0]    vcount,
  input  logic                   blank,
  input  logic                   frame_start,
  input  logic [NUM_SPRITES-1:0] trigger,
  output logic [NUM_SPRITES-1:0] sprites,
  output logic [NUM_SPRITES-1:0] active,
  output logic [HCOUNT_W-1:0]    hcount_d,
  output logic [VCOUNT_W-1:0]    vcount_d,
  output logic                   blank_d
);

  if ((FLASH_FRAMES < 1) || (FLASH_FRAMES > 255)) begin : g_bad_flash_frames
    $error("sprite_flash_mask: FLASH_FRAMES must be in 1..255");
  end

  logic [NUM_SPRITES-1:0] inbox;
  logic [NUM_SPRITES-1:0] lit;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
    localparam int unsigned XS = box_left(i, ORIGIN_X, COL_PITCH);
    localparam int unsigned YS = box_top(i, ORIGIN_Y, ROW_PITCH);

    if ((XS + SPR_W > SCREEN_W) || (YS + SPR_H > SCREEN_H)) begin : g_bad_layout
      $error("sprite_flash_mask: sprite box falls outside the visible area");
    end

    localparam logic [HCOUNT_W-1:0] X_LO = HCOUNT_W'(XS);
    localparam logic [HCOUNT_W-1:0] X_HI = HCOUNT_W'(XS + SPR_W);
    localparam logic [VCOUNT_W-1:0] Y_LO = VCOUNT_W'(YS);
    localparam logic [VCOUNT_W-1:0] Y_HI = VCOUNT_W'(YS + SPR_H);

    // Half-open box: [lo, hi) on both axes.
    assign inbox[i] = (hcount >= X_LO) && (hcount < X_HI) &&
                      (vcount >= Y_LO) && (vcount < Y_HI);

    sprite_flash_timer #(
      .FLASH_FRAMES(FLASH_FRAMES)
    ) u_timer (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (trigger[i]),
      .tick   (frame_start),
      .lit    (lit[i])
    );
  end

  logic [NUM_SPRITES-1:0] sprites_q, sprites_d;
  logic [HCOUNT_W-1:0]    hcount_q;
  logic [VCOUNT_W-1:0]    vcount_q;
  logic                   blank_q;

  // Overlapping boxes all assert; the selector resolves priority.
  always_comb begin
    sprites_d = inbox & lit & {NUM_SPRITES{~blank}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sprites_q <= '0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      blank_q   <= 1'b1;
    end else begin
      sprites_q <= sprites_d;
      hcount_q  <= hcount;
      vcount_q  <= vcount;
      blank_q   <= blank;
    end
  end

  assign sprites  = sprites_q;
  assign active   = lit;
  assign hcount_d = hcount_q;
  assign vcount_d = vcount_q;
  assign blank_d  = blank_q;

  blank_clears_sprites_a: assert property (@(posedge clk) disable iff (!reset_n)
    blank_d |-> (sprites == '0));

endmodule
